// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl shared definitions: FSM state encodings and store-lane alignment.
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        DMC_IDLE   = 2'd0,
        DMC_WAIT   = 2'd1,
        DMC_ACCESS = 2'd2,
        DMC_DONE   = 2'd3
    } dmc_state_t;

    localparam int CNT_W = 4;

    // Narrow stores arrive right-justified; spread them over every lane the mask can pick.
    function automatic logic [31:0] lane_align(input logic [3:0] be,
                                               input logic [31:0] wdata);
        logic [2:0] ones;
        logic [31:0] res;
        ones = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
        case (ones)
            3'd1:    res = {4{wdata[7:0]}};
            3'd2:    res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-addressed 32-bit synchronous RAM with byte write enables and registered read.
module dm_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wen,
    input  logic              ren,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Read register keeps the last loaded word until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rdata <= '0;
        else if (ren) rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: request latch, wait-state FSM and lane replication
// in front of dm_ram; pulses ready once per completed access.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmc_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       data_q;
    logic [3:0]        ram_wen;
    logic              ram_ren;
    logic              unused_addr;

    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DMC_IDLE;
            cnt    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            be_q   <= '0;
            data_q <= '0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                DMC_IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        addr_q <= addr[ADDR_W+1:2];
                        be_q   <= be;
                        data_q <= lane_align(be, wdata);
                        busy   <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state <= DMC_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= DMC_ACCESS;
                        end
                    end
                end
                DMC_WAIT: begin
                    if (cnt == '0) state <= DMC_ACCESS;
                    else           cnt   <= cnt - 1'b1;
                end
                DMC_ACCESS: begin
                    state <= DMC_DONE;
                    ready <= 1'b1;
                end
                DMC_DONE: begin
                    state <= DMC_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // RAM strobes are gated by the state, so a reset before ACCESS cannot write.
    assign ram_wen = (state == DMC_ACCESS && we_q) ? be_q : 4'b0000;
    assign ram_ren = (state == DMC_ACCESS) && !we_q;

    dm_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_q),
        .wen   (ram_wen),
        .ren   (ram_ren),
        .wdata (data_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: scoreboarded transactions on a WAIT_CYCLES=1
// instance, plus WAIT_CYCLES=0 and 5 instances for latency and spacing.
module tb_dm_ctrl;

    localparam int W1 = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata1, rdata0, rdata5;
    logic        ready1, ready0, ready5;
    logic        busy1, busy0, busy5;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(W1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .rdata(rdata1), .ready(ready1), .busy(busy1)
    );

    dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0)
    );

    dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
        .be(be), .wdata(wdata), .rdata(rdata5), .ready(ready5), .busy(busy5)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] e);
        exp_t x;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        x.is_load = !w;
        x.data    = e;
        x.edge_n  = cyc + 1;
        exp_q.push_back(x);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic collect(input string name);
        exp_t x;
        int n = 0;
        int lat;
        while (ready1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready1 !== 1'b1) begin
            $display("FAIL %s ready timeout: got %b want 1", name, ready1);
            if (exp_q.size() > 0) x = exp_q.pop_front();
            return;
        end
        if (exp_q.size() == 0) begin
            $display("FAIL %s unexpected ready: got 1 want no pending txn", name);
            return;
        end
        x = exp_q.pop_front();
        lat = cyc - x.edge_n + 1;
        if (lat !== W1 + 2)
            $display("FAIL %s latency: got %0d want %0d", name, lat, W1 + 2);
        else passed++;
        if (x.is_load) begin
            checks++;
            if (rdata1 !== x.data)
                $display("FAIL %s rdata: got %h want %h", name, rdata1, x.data);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (ready1 !== 1'b0)
            $display("FAIL %s ready width: got %b want 0", name, ready1);
        else passed++;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input string name);
        issue(1'b1, a, b, d, 32'h0);
        collect(name);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] e,
                        input string name);
        issue(1'b0, a, 4'hF, 32'h0, e);
        collect(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy1 | busy0 | busy5) !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((busy1 | busy0 | busy5) !== 1'b0) begin
            checks++;
            $display("FAIL %s idle timeout: got busy %b%b%b want 000",
                     name, busy1, busy0, busy5);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready1 !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready1);
        else passed++;
        checks++;
        if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1);
        else passed++;
        checks++;
        if (rdata1 !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata1);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word;
        store(32'h10, 4'b1111, 32'hDEADBEEF, "sw_word");
        load(32'h10, 32'hDEADBEEF, "lw_word");
    endtask

    task automatic test_byte;
        store(32'h10, 4'b1111, 32'h0, "sw_clear");
        store(32'h11, 4'b0010, 32'h000000A5, "sb_lane1");
        load(32'h10, 32'h0000A500, "lw_byte");
        store(32'h70, 4'b1111, 32'h0, "sw_clear2");
        store(32'h70, 4'b0101, 32'h0000BEEF, "s_be0101");
        load(32'h70, 32'h00EF00EF, "lw_be0101");
        store(32'h74, 4'b1111, 32'h0, "sw_clear3");
        store(32'h74, 4'b0111, 32'h11223344, "s_be0111");
        load(32'h74, 32'h00223344, "lw_be0111");
    endtask

    task automatic test_half;
        store(32'h50, 4'b1111, 32'hFFFFFFFF, "sw_ones");
        store(32'h52, 4'b1100, 32'h00001234, "sh_upper");
        load(32'h50, 32'h1234FFFF, "lw_half");
        store(32'h50, 4'b0000, 32'h00005678, "s_be0000");
        load(32'h50, 32'h1234FFFF, "lw_be0000");
    endtask

    task automatic test_ignore;
        int cnt = 0;
        wait_idle("ignore_pre");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (busy1 !== 1'b1) $display("FAIL busy_wait: got %b want 1", busy1);
                else passed++;
            end
            if (ready1 === 1'b1) cnt++;
            wdata = 32'hBAD0BAD0;
            req = (i < 2);
        end
        checks++;
        if (cnt !== 1) $display("FAIL ignore_ready_count: got %0d want 1", cnt);
        else passed++;
        load(32'h20, 32'hCAFEF00D, "lw_ignore");
    endtask

    task automatic test_back_to_back;
        int t1[$];
        int t0[$];
        wait_idle("b2b_pre");
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20; be = 4'hF; wdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready1 === 1'b1) begin
                t1.push_back(cyc);
                if (t1.size() == 1) begin
                    checks++;
                    if (rdata1 !== 32'hCAFEF00D)
                        $display("FAIL b2b_rdata: got %h want cafef00d", rdata1);
                    else passed++;
                end
            end
            if (ready0 === 1'b1) t0.push_back(cyc);
        end
        req = 1'b0;
        checks++;
        if (t1.size() < 3 || t0.size() < 3) begin
            $display("FAIL b2b_pulses: got %0d/%0d want >=3", t1.size(), t0.size());
        end else begin
            passed++;
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (t1[k] - t1[k-1] !== W1 + 3)
                    $display("FAIL b2b_gap_w1: got %0d want %0d",
                             t1[k] - t1[k-1], W1 + 3);
                else passed++;
                checks++;
                if (t0[k] - t0[k-1] !== 3)
                    $display("FAIL b2b_gap_w0: got %0d want 3", t0[k] - t0[k-1]);
                else passed++;
            end
        end
        wait_idle("b2b_post");
    endtask

    task automatic test_abort;
        int cnt = 0;
        store(32'h30, 4'b1111, 32'h11111111, "sw_pre_abort");
        wait_idle("abort_pre");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'h55555555;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy1);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready1 === 1'b1) cnt++;
        end
        checks++;
        if (cnt !== 0) $display("FAIL abort_ready: got %0d want 0", cnt);
        else passed++;
        load(32'h30, 32'h11111111, "lw_abort");
    endtask

    task automatic test_latency;
        int e;
        int l0 = -1;
        int l1 = -1;
        int l5 = -1;
        wait_idle("lat_pre");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'h0F0F0F0F;
        e = cyc + 1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ready0 === 1'b1 && l0 < 0) l0 = cyc - e + 1;
            if (ready1 === 1'b1 && l1 < 0) l1 = cyc - e + 1;
            if (ready5 === 1'b1 && l5 < 0) l5 = cyc - e + 1;
            @(negedge clk);
        end
        checks++;
        if (l0 !== 2) $display("FAIL lat_w0: got %0d want 2", l0);
        else passed++;
        checks++;
        if (l1 !== 3) $display("FAIL lat_w1: got %0d want 3", l1);
        else passed++;
        checks++;
        if (l5 !== 7) $display("FAIL lat_w5: got %0d want 7", l5);
        else passed++;
        wait_idle("lat_post");
        store(32'h1000, 4'b1111, 32'h13579BDF, "sw_wrap");
        load(32'h0, 32'h13579BDF, "lw_wrap");
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_ignore();
        test_back_to_back();
        test_abort();
        test_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
